// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive and transmit paths: channel FSM
// states, bit-counter width and the legal range of the parallel word width.
package i2s_pkg;

    // Bit counter width; the counter saturates at 2**CNT_W - 1.
    localparam int CNT_W     = 6;

    // Legal range of the parallel sample width.
    localparam int WIDTH_MIN = 8;
    localparam int WIDTH_MAX = 32;

    // Channel framing state.
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// N-stage synchronizer for one asynchronous input, with an optional
// registered rising-edge strobe derived from the last two synchronized samples.
module i2s_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [STAGES-1:0] sync_r;

    // Synchronizer chain; the newest sample enters at bit 0
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
        end
    end

    assign dout = sync_r[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic last_r;
            logic rise_r;

            // Rising-edge strobe: synchronized output is 1 while its previous sample was 0
            always_ff @(posedge CLK) begin
                if (RST) begin
                    last_r <= 1'b0;
                    rise_r <= 1'b0;
                end else begin
                    last_r <= sync_r[STAGES-1];
                    rise_r <= sync_r[STAGES-1] & ~last_r;
                end
            end

            assign rise = rise_r;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_receiver.sv
// Slave-mode I2S receiver. BCK/WS/SDIN are synchronized into CLK, standard
// I2S framing (MSB one BCK after the WS edge) is decoded and each completed
// left/right pair is presented on DATA_L/DATA_R with a one-cycle VALID.
// Optional build macro I2S_RX_FRAME_CHECK_EN: rejects pairs whose slot bit
// counts are short or unequal, pulsing FRAME_ERR instead of VALID.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BCK,
    input  logic             WS,
    input  logic             SDIN,
    output logic [WIDTH-1:0] DATA_L,
    output logic [WIDTH-1:0] DATA_R,
    output logic             VALID,
    output logic             FRAME_ERR
);

    logic             bck_rise_s;
    logic             ws_s;
    logic             sd_s;
    logic             unused_bck_s;
    logic             unused_ws_rise_s;
    logic             unused_sd_rise_s;

    i2s_state_e       state_r;
    i2s_state_e       state_nxt_s;

    logic             ws_p_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] word_nxt_s;
    logic [WIDTH-1:0] left_hold_r;
    logic [WIDTH-1:0] data_l_r;
    logic [WIDTH-1:0] data_r_r;
    logic             valid_r;

    logic             boundary_s;
    logic             close_left_s;
    logic             close_right_s;
    logic             pair_bad_s;
    logic             emit_valid_s;

    i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_bck (
        .CLK  (CLK),
        .RST  (RST),
        .din  (BCK),
        .dout (unused_bck_s),
        .rise (bck_rise_s)
    );

    i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_ws (
        .CLK  (CLK),
        .RST  (RST),
        .din  (WS),
        .dout (ws_s),
        .rise (unused_ws_rise_s)
    );

    i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sd (
        .CLK  (CLK),
        .RST  (RST),
        .din  (SDIN),
        .dout (sd_s),
        .rise (unused_sd_rise_s)
    );

    // A channel boundary is a sampled WS value differing from the previous sample
    assign boundary_s = bck_rise_s & (ws_s != ws_p_r);

    // Saturating increment of the per-channel bit count
    always_comb begin
        if (cnt_r == {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end
    end

    // Current word with the incoming bit placed MSB-first; bits past WIDTH fall away
    always_comb begin
        word_nxt_s = shift_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_r == CNT_W'(WIDTH - 1 - i)) begin
                word_nxt_s[i] = sd_s;
            end else begin
                word_nxt_s[i] = shift_r[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: lock on a 1->0 boundary, then alternate LEFT/RIGHT
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            HUNT: begin
                if (boundary_s && !ws_s) begin
                    state_nxt_s = LEFT;
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            LEFT: begin
                if (boundary_s && ws_s) begin
                    state_nxt_s = RIGHT;
                end else begin
                    state_nxt_s = LEFT;
                end
            end
            RIGHT: begin
                if (boundary_s && !ws_s) begin
                    state_nxt_s = LEFT;
                end else begin
                    state_nxt_s = RIGHT;
                end
            end
            default: begin
                state_nxt_s = HUNT;
            end
        endcase
    end

    // FSM outputs: channel-close strobes for the left and right slots
    always_comb begin
        close_left_s  = 1'b0;
        close_right_s = 1'b0;
        case (state_r)
            LEFT: begin
                if (boundary_s && ws_s) begin
                    close_left_s = 1'b1;
                end else begin
                    close_left_s = 1'b0;
                end
            end
            RIGHT: begin
                if (boundary_s && !ws_s) begin
                    close_right_s = 1'b1;
                end else begin
                    close_right_s = 1'b0;
                end
            end
            default: begin
                close_left_s  = 1'b0;
                close_right_s = 1'b0;
            end
        endcase
    end

    // Shift word, bit count and previous WS sample; a boundary closes the channel
    always_ff @(posedge CLK) begin
        if (RST) begin
            ws_p_r  <= 1'b0;
            cnt_r   <= '0;
            shift_r <= '0;
        end else if (bck_rise_s) begin
            ws_p_r <= ws_s;
            if (boundary_s) begin
                cnt_r   <= '0;
                shift_r <= '0;
            end else begin
                cnt_r   <= cnt_inc_s;
                shift_r <= word_nxt_s;
            end
        end else begin
            ws_p_r  <= ws_p_r;
            cnt_r   <= cnt_r;
            shift_r <= shift_r;
        end
    end

    // Left hold keeps the closed left word until the matching right word completes
    always_ff @(posedge CLK) begin
        if (RST) begin
            left_hold_r <= '0;
        end else if (close_left_s) begin
            left_hold_r <= word_nxt_s;
        end else begin
            left_hold_r <= left_hold_r;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic [CNT_W-1:0] left_cnt_r;
    logic             frame_err_r;

    // Left slot bit count, closing bit included
    always_ff @(posedge CLK) begin
        if (RST) begin
            left_cnt_r <= '0;
        end else if (close_left_s) begin
            left_cnt_r <= cnt_inc_s;
        end else begin
            left_cnt_r <= left_cnt_r;
        end
    end

    // A pair is rejected when either slot is short or the two slot lengths differ
    always_comb begin
        if ((left_cnt_r < CNT_W'(WIDTH)) || (cnt_inc_s < CNT_W'(WIDTH)) ||
            (left_cnt_r != cnt_inc_s)) begin
            pair_bad_s = 1'b1;
        end else begin
            pair_bad_s = 1'b0;
        end
    end

    // One-cycle frame error pulse on a rejected pair
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= close_right_s & pair_bad_s;
        end
    end

    assign FRAME_ERR = frame_err_r;
`else
    assign pair_bad_s = 1'b0;
    assign FRAME_ERR  = 1'b0;
`endif

    assign emit_valid_s = close_right_s & ~pair_bad_s;

    // Output words and VALID strobe; words hold between accepted pairs
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_l_r <= '0;
            data_r_r <= '0;
            valid_r  <= 1'b0;
        end else if (emit_valid_s) begin
            data_l_r <= left_hold_r;
            data_r_r <= word_nxt_s;
            valid_r  <= 1'b1;
        end else begin
            data_l_r <= data_l_r;
            data_r_r <= data_r_r;
            valid_r  <= 1'b0;
        end
    end

    assign DATA_L = data_l_r;
    assign DATA_R = data_r_r;
    assign VALID  = valid_r;

endmodule
